// File: rtl/raymarch_scheduler.sv
// Raster-order pixel dispatcher for NUM_CORES raymarcher cores with round-robin writeback.
// Define PERF_COUNT_EN to add frame_cycles_out (cycles per completed frame).
module raymarch_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    output logic [NUM_CORES-1:0]          core_start_out,
    output logic [XW-1:0]                 core_x_out,
    output logic [YW-1:0]                 core_y_out,
    input  logic [NUM_CORES-1:0]          core_done_in,
    input  logic [24*NUM_CORES-1:0]       core_rgb_in,
    input  logic [(XW+YW)*NUM_CORES-1:0]  core_xy_in,
    output logic                          px_valid_out,
    input  logic                          px_ready_in,
    output logic [XW-1:0]                 px_x_out,
    output logic [YW-1:0]                 px_y_out,
    output logic [23:0]                   px_rgb_out,
    output logic                          frame_done_out,
    output logic [31:0]                   timer_out
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0]                   frame_cycles_out
`endif
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} slot_t;

    slot_t             r_state     [NUM_CORES];
    slot_t             w_state_nxt [NUM_CORES];
    logic [23:0]       r_hold_rgb  [NUM_CORES];
    logic [XW+YW-1:0]  r_hold_xy   [NUM_CORES];

    logic [PW-1:0]         r_disp_ptr, r_wb_ptr;
    logic [PW-1:0]         w_disp_idx, w_wb_idx;
    logic                  w_disp_found, w_wb_found;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic                  r_issued_all;
    logic [CW-1:0]         r_wr_cnt;
    logic [NUM_CORES-1:0]  r_start;
    logic [XW-1:0]         r_core_x;
    logic [YW-1:0]         r_core_y;
    logic                  r_px_valid;
    logic [XW-1:0]         r_px_x;
    logic [YW-1:0]         r_px_y;
    logic [23:0]           r_px_rgb;
    logic                  r_frame_done;
    logic [31:0]           r_timer;
    logic                  w_accept, w_load, w_frame_end, w_dispatch, w_wb;

    assign w_accept    = r_px_valid & px_ready_in;
    assign w_load      = ~r_px_valid | px_ready_in;
    assign w_frame_end = w_accept && (r_wr_cnt == CW'(TOTAL - 1));
    assign w_dispatch  = enable_in & w_disp_found & ~r_issued_all;
    assign w_wb        = w_load & w_wb_found;

    // Round-robin search: first IDLE slot from dispatch_ptr, first HOLD slot from wb_ptr
    always_comb begin : p_arb
        int jd;
        int jw;
        jd           = 0;
        jw           = 0;
        w_disp_found = 1'b0;
        w_disp_idx   = '0;
        w_wb_found   = 1'b0;
        w_wb_idx     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            jd = (int'(r_disp_ptr) + k) % NUM_CORES;
            jw = (int'(r_wb_ptr) + k) % NUM_CORES;
            if (!w_disp_found && r_state[jd] == S_IDLE) begin
                w_disp_found = 1'b1;
                w_disp_idx   = PW'(jd);
            end
            if (!w_wb_found && r_state[jw] == S_HOLD) begin
                w_wb_found = 1'b1;
                w_wb_idx   = PW'(jw);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_state_nxt[i] = r_state[i];
            unique case (r_state[i])
                S_IDLE:  if (w_dispatch && w_disp_idx == PW'(i)) w_state_nxt[i] = S_BUSY;
                S_BUSY:  if (core_done_in[i]) w_state_nxt[i] = S_HOLD;
                S_HOLD:  if (w_wb && w_wb_idx == PW'(i)) w_state_nxt[i] = S_IDLE;
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_state[i]    <= S_IDLE;
                r_hold_rgb[i] <= '0;
                r_hold_xy[i]  <= '0;
            end
            r_disp_ptr   <= '0;
            r_wb_ptr     <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_issued_all <= 1'b0;
            r_wr_cnt     <= '0;
            r_start      <= '0;
            r_core_x     <= '0;
            r_core_y     <= '0;
            r_px_valid   <= 1'b0;
            r_px_x       <= '0;
            r_px_y       <= '0;
            r_px_rgb     <= '0;
            r_frame_done <= 1'b0;
            r_timer      <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (r_state[i] == S_BUSY && core_done_in[i]) begin
                    r_hold_rgb[i] <= core_rgb_in[24*i +: 24];
                    r_hold_xy[i]  <= core_xy_in[(XW+YW)*i +: (XW+YW)];
                end
            end
            r_start <= '0;
            if (w_dispatch) begin
                r_start[w_disp_idx] <= 1'b1;
                r_core_x   <= r_x;
                r_core_y   <= r_y;
                r_disp_ptr <= (w_disp_idx == PW'(NUM_CORES - 1)) ? '0 : w_disp_idx + 1'b1;
                if (r_x == XW'(WIDTH - 1)) begin
                    r_x <= '0;
                    if (r_y == YW'(HEIGHT - 1)) begin
                        r_y          <= '0;
                        r_issued_all <= 1'b1;
                    end else begin
                        r_y <= r_y + 1'b1;
                    end
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            if (w_load) begin
                r_px_valid <= w_wb_found;
                if (w_wb_found) begin
                    r_px_x   <= r_hold_xy[w_wb_idx][XW+YW-1:YW];
                    r_px_y   <= r_hold_xy[w_wb_idx][YW-1:0];
                    r_px_rgb <= r_hold_rgb[w_wb_idx];
                    r_wb_ptr <= (w_wb_idx == PW'(NUM_CORES - 1)) ? '0 : w_wb_idx + 1'b1;
                end
            end
            if (w_accept) r_wr_cnt <= r_wr_cnt + 1'b1;
            r_frame_done <= w_frame_end;
            // Barrier release: the next frame may dispatch from the following cycle
            if (w_frame_end) begin
                r_timer      <= r_timer + 32'd1;
                r_wr_cnt     <= '0;
                r_issued_all <= 1'b0;
                r_x          <= '0;
                r_y          <= '0;
            end
        end
    end

`ifdef PERF_COUNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_frame_cycles;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cyc_cnt      <= '0;
            r_frame_cycles <= '0;
        end else if (w_frame_end) begin
            r_frame_cycles <= r_cyc_cnt + 32'd1;
            r_cyc_cnt      <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    assign frame_cycles_out = r_frame_cycles;
`endif

    assign core_start_out = r_start;
    assign core_x_out     = r_core_x;
    assign core_y_out     = r_core_y;
    assign px_valid_out   = r_px_valid;
    assign px_x_out       = r_px_x;
    assign px_y_out       = r_px_y;
    assign px_rgb_out     = r_px_rgb;
    assign frame_done_out = r_frame_done;
    assign timer_out      = r_timer;

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Bench for raymarch_scheduler: 2 cores, 4x2 frame, fixed-latency core models,
// table-driven raster check plus directed multi-cycle corner sequences.
module tb_raymarch_scheduler;

    localparam int NC = 2;
    localparam int W  = 4;
    localparam int H  = 2;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [1:0]  core_start_out;
    logic [1:0]  core_x_out;
    logic        core_y_out;
    logic [1:0]  core_done_in;
    logic [47:0] core_rgb_in;
    logic [5:0]  core_xy_in;
    logic        px_valid_out;
    logic        px_ready_in;
    logic [1:0]  px_x_out;
    logic        px_y_out;
    logic [23:0] px_rgb_out;
    logic        frame_done_out;
    logic [31:0] timer_out;
`ifdef PERF_COUNT_EN
    logic [31:0] frame_cycles_out;
`endif

    always #5 clk = ~clk;

    raymarch_scheduler #(.NUM_CORES(NC), .WIDTH(W), .HEIGHT(H)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .core_start_out (core_start_out),
        .core_x_out     (core_x_out),
        .core_y_out     (core_y_out),
        .core_done_in   (core_done_in),
        .core_rgb_in    (core_rgb_in),
        .core_xy_in     (core_xy_in),
        .px_valid_out   (px_valid_out),
        .px_ready_in    (px_ready_in),
        .px_x_out       (px_x_out),
        .px_y_out       (px_y_out),
        .px_rgb_out     (px_rgb_out),
        .frame_done_out (frame_done_out),
        .timer_out      (timer_out)
`ifdef PERF_COUNT_EN
        ,
        .frame_cycles_out (frame_cycles_out)
`endif
    );

    function automatic logic [23:0] rgb_of(input logic [1:0] x, input logic y);
        return {8'h10 + {6'd0, x}, 8'h20 + {7'd0, y}, 8'h40 + {6'd0, x} + {5'd0, y, 2'b00}};
    endfunction

    // Fixed-latency core models, reset by the shared rst_in
    int         lat [NC];
    int         m_cnt [NC];
    logic [1:0] m_x [NC];
    logic       m_y [NC];
    logic [1:0] m_done;
    logic [1:0] spur;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rst_in) begin
                m_cnt[i]  <= 0;
                m_x[i]    <= '0;
                m_y[i]    <= 1'b0;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (core_start_out[i]) begin
                    m_x[i]   <= core_x_out;
                    m_y[i]   <= core_y_out;
                    m_cnt[i] <= lat[i];
                end else if (m_cnt[i] > 1) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end else if (m_cnt[i] == 1) begin
                    m_done[i] <= 1'b1;
                    m_cnt[i]  <= 0;
                end
            end
        end
    end

    assign core_done_in = m_done | spur;
    assign core_rgb_in  = {rgb_of(m_x[1], m_y[1]), rgb_of(m_x[0], m_y[0])};
    assign core_xy_in   = {m_x[1], m_y[1], m_x[0], m_y[0]};

    typedef struct {
        int         cyc;
        logic [1:0] mask;
        logic [1:0] x;
        logic       y;
    } st_t;

    typedef struct {
        logic [1:0]  x;
        logic        y;
        logic [23:0] rgb;
    } px_t;

    st_t st_q[$];
    px_t px_q[$];
    st_t mon_s;
    px_t mon_p;
    int  fd_cnt;
    int  cyc;

    always @(posedge clk) cyc <= rst_in ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (rst_in) begin
            st_q.delete();
            px_q.delete();
            fd_cnt = 0;
        end else begin
            if (core_start_out != 2'b00) begin
                mon_s.cyc  = cyc;
                mon_s.mask = core_start_out;
                mon_s.x    = core_x_out;
                mon_s.y    = core_y_out;
                st_q.push_back(mon_s);
            end
            if (px_valid_out && px_ready_in) begin
                mon_p.x   = px_x_out;
                mon_p.y   = px_y_out;
                mon_p.rgb = px_rgb_out;
                px_q.push_back(mon_p);
            end
            if (frame_done_out) fd_cnt = fd_cnt + 1;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int l0, input int l1);
        rst_in      = 1'b1;
        enable_in   = 1'b0;
        px_ready_in = 1'b0;
        spur        = 2'b00;
        lat[0]      = l0;
        lat[1]      = l1;
        tick(2);
        chk("rst_outs", 32'({core_start_out, core_x_out, core_y_out, px_valid_out,
                             px_x_out, px_y_out, frame_done_out}), 32'd0);
        chk("rst_rgb", 32'(px_rgb_out), 32'd0);
        chk("rst_timer", timer_out, 32'd0);
        rst_in = 1'b0;
    endtask

    typedef struct {
        int          hold;
        logic [1:0]  x;
        logic        y;
        logic [23:0] rgb;
    } vec_t;

    vec_t        tv [8];
    int          n;
    int          k;
    logic        stable;
    logic [26:0] snap;
    logic [7:0]  seen;
    logic        rgb_ok;
    int          fc [3];

    initial begin
        rst_in      = 1'b1;
        enable_in   = 1'b0;
        px_ready_in = 1'b0;
        spur        = 2'b00;
        lat[0]      = 5;
        lat[1]      = 5;

        tv[0] = '{0, 2'd0, 1'b0, 24'h102040};
        tv[1] = '{0, 2'd1, 1'b0, 24'h112041};
        tv[2] = '{3, 2'd2, 1'b0, 24'h122042};
        tv[3] = '{0, 2'd3, 1'b0, 24'h132043};
        tv[4] = '{0, 2'd0, 1'b1, 24'h102144};
        tv[5] = '{1, 2'd1, 1'b1, 24'h112145};
        tv[6] = '{0, 2'd2, 1'b1, 24'h122146};
        tv[7] = '{2, 2'd3, 1'b1, 24'h132147};

        // Full frame, raster order, with downstream stalls from the table
        do_reset(5, 5);
        enable_in = 1'b1;
        for (int v = 0; v < 8; v++) begin
            px_ready_in = 1'b0;
            n = 0;
            while (!px_valid_out && n < 100) begin
                tick();
                n++;
            end
            chk("t1_wait", 32'(n < 100), 32'd1);
            snap   = {px_x_out, px_y_out, px_rgb_out};
            stable = 1'b1;
            for (int h = 0; h < tv[v].hold; h++) begin
                tick();
                if (!px_valid_out || {px_x_out, px_y_out, px_rgb_out} !== snap) stable = 1'b0;
            end
            chk("t1_stable", 32'(stable), 32'd1);
            chk("t1_xy", 32'({px_x_out, px_y_out}), 32'({tv[v].x, tv[v].y}));
            chk("t1_rgb", 32'(px_rgb_out), 32'(tv[v].rgb));
            px_ready_in = 1'b1;
            tick();
        end
        chk("t1_fdone", 32'(frame_done_out), 32'd1);
        chk("t1_timer", timer_out, 32'd1);
        chk("t1_nstarts", 32'(st_q.size()), 32'd8);
        chk("t1_st0", 32'({st_q[0].mask, st_q[0].x, st_q[0].y}), 32'b01_00_0);
        chk("t1_st0_cyc", 32'(st_q[0].cyc), 32'd1);
        chk("t1_st1", 32'({st_q[1].mask, st_q[1].x, st_q[1].y}), 32'b10_01_0);
        chk("t1_st1_cyc", 32'(st_q[1].cyc), 32'd2);
        px_ready_in = 1'b0;
        tick();
        chk("t1_fd_pulse", 32'(frame_done_out), 32'd0);
        chk("t1_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("t1_next_start", 32'({core_start_out, core_x_out, core_y_out}), 32'b01_00_0);
        enable_in = 1'b0;

        // Unequal latencies: completion order, each pixel exactly once
        do_reset(20, 3);
        px_ready_in = 1'b1;
        enable_in   = 1'b1;
        n = 0;
        while (px_q.size() < 8 && n < 300) begin
            tick();
            n++;
        end
        chk("t2_wait", 32'(n < 300), 32'd1);
        tick(2);
        enable_in = 1'b0;
        if (px_q.size() >= 8) begin
            chk("t2_first", 32'({px_q[0].x, px_q[0].y}), 32'b01_0);
            chk("t2_second", 32'({px_q[1].x, px_q[1].y}), 32'b10_0);
            seen   = '0;
            rgb_ok = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (seen[{px_q[i].y, px_q[i].x}]) rgb_ok = 1'b0;
                seen[{px_q[i].y, px_q[i].x}] = 1'b1;
                if (px_q[i].rgb !== rgb_of(px_q[i].x, px_q[i].y)) rgb_ok = 1'b0;
            end
            chk("t2_all_seen", 32'(seen), 32'hFF);
            chk("t2_once_rgb", 32'(rgb_ok), 32'd1);
        end
        chk("t2_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("t2_timer", timer_out, 32'd1);

        // Downstream stall with both slots holding results
        do_reset(5, 5);
        enable_in = 1'b1;
        tick(25);
        chk("t3_valid", 32'(px_valid_out), 32'd1);
        chk("t3_head", 32'({px_x_out, px_y_out, px_rgb_out}), 32'({2'd0, 1'b0, 24'h102040}));
        snap   = {px_x_out, px_y_out, px_rgb_out};
        stable = 1'b1;
        for (int h = 0; h < 10; h++) begin
            tick();
            if (!px_valid_out || core_start_out != 2'b00 ||
                {px_x_out, px_y_out, px_rgb_out} !== snap) stable = 1'b0;
        end
        chk("t3_held", 32'(stable), 32'd1);
        chk("t3_nstarts", 32'(st_q.size()), 32'd3);
        px_ready_in = 1'b1;
        tick();
        chk("t3_drain1", 32'({px_valid_out, px_x_out, px_y_out}), 32'b1_01_0);
        tick();
        chk("t3_drain2", 32'({px_valid_out, px_x_out, px_y_out}), 32'b1_10_0);
        chk("t3_drain2_rgb", 32'(px_rgb_out), 32'h122042);

        // Spurious done on an IDLE slot
        do_reset(5, 5);
        px_ready_in = 1'b1;
        spur = 2'b01;
        tick();
        spur = 2'b00;
        tick(10);
        chk("t4_quiet", 32'({px_valid_out, core_start_out}), 32'd0);
        chk("t4_npx", 32'(px_q.size()), 32'd0);
        enable_in = 1'b1;
        n = 0;
        while (px_q.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        chk("t4_wait", 32'(n < 50), 32'd1);
        if (px_q.size() >= 1) begin
            chk("t4_first", 32'({px_q[0].x, px_q[0].y, px_q[0].rgb}), 32'({2'd0, 1'b0, 24'h102040}));
            chk("t4_st0", 32'({st_q[0].mask, st_q[0].x, st_q[0].y}), 32'b01_00_0);
        end
        enable_in = 1'b0;

        // Drop enable after three starts, then resume
        do_reset(5, 5);
        px_ready_in = 1'b1;
        enable_in   = 1'b1;
        n = 0;
        k = 0;
        while (n < 3 && k < 100) begin
            tick();
            k++;
            if (core_start_out != 2'b00) n++;
        end
        enable_in = 1'b0;
        chk("t5_three", 32'(n), 32'd3);
        tick(40);
        chk("t5_nstarts", 32'(st_q.size()), 32'd3);
        chk("t5_npx", 32'(px_q.size()), 32'd3);
        chk("t5_idle", 32'(px_valid_out), 32'd0);
        enable_in = 1'b1;
        n = 0;
        while (st_q.size() < 4 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_wait", 32'(n < 20), 32'd1);
        if (st_q.size() >= 4)
            chk("t5_resume", 32'({st_q[3].x, st_q[3].y}), 32'b11_0);
        enable_in = 1'b0;

        // Reset while both cores are busy on the second frame
        do_reset(5, 5);
        px_ready_in = 1'b1;
        enable_in   = 1'b1;
        n = 0;
        while (!frame_done_out && n < 200) begin
            tick();
            n++;
        end
        chk("t6_frame", 32'(n < 200), 32'd1);
        chk("t6_timer1", timer_out, 32'd1);
        n = 0;
        k = 0;
        while (n < 2 && k < 20) begin
            tick();
            k++;
            if (core_start_out != 2'b00) n++;
        end
        chk("t6_two_busy", 32'(n), 32'd2);
        rst_in = 1'b1;
        tick();
        chk("t6_rst_outs", 32'({core_start_out, px_valid_out, frame_done_out,
                                 px_x_out, px_y_out}), 32'd0);
        chk("t6_rst_timer", timer_out, 32'd0);
        rst_in = 1'b0;
        n = 0;
        while (px_q.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_wait", 32'(n < 50), 32'd1);
        if (px_q.size() >= 1) begin
            chk("t6_st0", 32'({st_q[0].mask, st_q[0].x, st_q[0].y}), 32'b01_00_0);
            chk("t6_px0", 32'({px_q[0].x, px_q[0].y}), 32'd0);
        end
        chk("t6_timer0", timer_out, 32'd0);
        enable_in = 1'b0;

`ifdef PERF_COUNT_EN
        do_reset(5, 5);
        chk("p_rst", frame_cycles_out, 32'd0);
        px_ready_in = 1'b1;
        enable_in   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (!frame_done_out && n < 200) begin
                tick();
                n++;
            end
            chk("p_wait", 32'(n < 200), 32'd1);
            fc[f] = int'(frame_cycles_out);
            tick();
        end
        chk("p_nonzero", 32'(fc[1] != 0), 32'd1);
        chk("p_repeat", 32'(fc[2]), 32'(fc[1]));
        enable_in = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
